// File: rtl/syn_dp_ram_param.sv
// Byte-enabled dual-port RAM with a post-reset clear sweep.
// Define SYN_DP_RAM_BYPASS_EN to forward write data on a same-address read.
module syn_dp_ram_param #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 16,
   parameter int ADDR_SIZE = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   write,
   input  logic [ADDR_SIZE-1:0]   write_addr,
   input  logic [RAM_WIDTH-1:0]   data_in,
   input  logic [RAM_WIDTH/8-1:0] byte_en,
   input  logic                   read,
   input  logic [ADDR_SIZE-1:0]   read_addr,
   output logic [RAM_WIDTH-1:0]   data_out,
   output logic                   read_valid,
   output logic                   busy
);

   localparam int NB = RAM_WIDTH / 8;
   localparam logic [ADDR_SIZE:0] DEPTH_W =
      (ADDR_SIZE+1)'(RAM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST =
      ADDR_SIZE'(RAM_DEPTH - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t               state;
   logic [ADDR_SIZE-1:0] clr_cnt;
   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   logic                 wr_in_range;
   logic                 rd_in_range;
   logic                 wr_en;
   logic                 clr_en;
   logic                 rd_en;
   logic [RAM_WIDTH-1:0] rd_word;

   assign wr_in_range = {1'b0, write_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, read_addr} < DEPTH_W;

   assign clr_en = !reset && (state == CLEAR);
   assign wr_en  = !reset && (state == READY)
                   && write && wr_in_range;
   assign rd_en  = !reset && (state == READY) && read;

   // Out-of-range reads return zero rather than aliasing.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[read_addr];
      end
`ifdef SYN_DP_RAM_BYPASS_EN
      if (wr_en && (write_addr == read_addr)) begin
         for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
               rd_word[8*k +: 8] = data_in[8*k +: 8];
            end
         end
      end
`endif
   end

   // Storage has no reset; the sweep zeroes it afterwards.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
               mem[write_addr][8*k +: 8] <= data_in[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         busy       <= 1'b1;
         data_out   <= '0;
         read_valid <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               read_valid <= 1'b0;
               clr_cnt    <= clr_cnt + ADDR_SIZE'(1);
               if (clr_cnt == LAST) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               read_valid <= rd_en;
               if (rd_en) begin
                  data_out <= rd_word;
               end
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_syn_dp_ram_param.sv
// Bench for syn_dp_ram_param: a default 8x16 instance and
// a 16-bit x 12-word instance driven in lockstep.
module tb_syn_dp_ram_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        write;
   logic [3:0]  write_addr;
   logic        read;
   logic [3:0]  read_addr;

   logic [7:0]  a_din;
   logic [0:0]  a_be;
   logic [7:0]  a_dout;
   logic        a_rv;
   logic        a_busy;

   logic [15:0] b_din;
   logic [1:0]  b_be;
   logic [15:0] b_dout;
   logic        b_rv;
   logic        b_busy;

   logic [7:0]  ma [16];
   logic [15:0] mb [12];
   logic [7:0]  qa [$];
   logic [15:0] qb [$];
   logic [7:0]  last_a;
   logic [15:0] last_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   syn_dp_ram_param dut_a (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .write_addr (write_addr),
      .data_in    (a_din),
      .byte_en    (a_be),
      .read       (read),
      .read_addr  (read_addr),
      .data_out   (a_dout),
      .read_valid (a_rv),
      .busy       (a_busy)
   );

   syn_dp_ram_param #(
      .RAM_WIDTH (16),
      .RAM_DEPTH (12),
      .ADDR_SIZE (4)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .write      (write),
      .write_addr (write_addr),
      .data_in    (b_din),
      .byte_en    (b_be),
      .read       (read),
      .read_addr  (read_addr),
      .data_out   (b_dout),
      .read_valid (b_rv),
      .busy       (b_busy)
   );

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check();
      logic [7:0]  ea;
      logic [15:0] eb;
      if (a_rv) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_valid", 16'(a_rv), 16'h0);
         end else begin
            ea = qa.pop_front();
            chk("a_data", 16'(a_dout), 16'(ea));
            last_a = ea;
         end
      end
      if (b_rv) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_valid", 16'(b_rv), 16'h0);
         end else begin
            eb = qb.pop_front();
            chk("b_data", b_dout, eb);
            last_b = eb;
         end
      end
   endtask

   task automatic op(input bit wr, input logic [3:0] wa,
                     input logic [7:0] da, input logic ba,
                     input logic [15:0] db, input logic [1:0] bb,
                     input bit rd, input logic [3:0] ra);
      logic [7:0]  ea;
      logic [15:0] eb;
      @(negedge clk);
      write = wr; write_addr = wa;
      a_din = da; a_be = ba;
      b_din = db; b_be = bb;
      read = rd; read_addr = ra;
      if (rd) begin
         ea = ma[ra];
         eb = (ra < 12) ? mb[ra] : 16'h0;
`ifdef SYN_DP_RAM_BYPASS_EN
         if (wr && wa == ra) begin
            if (ba) ea = da;
            if (wa < 12) begin
               for (int k = 0; k < 2; k++)
                  if (bb[k]) eb[8*k +: 8] = db[8*k +: 8];
            end
         end
`endif
         qa.push_back(ea);
         qb.push_back(eb);
      end
      if (wr) begin
         if (ba) ma[wa] = da;
         if (wa < 12) begin
            for (int k = 0; k < 2; k++)
               if (bb[k]) mb[wa][8*k +: 8] = db[8*k +: 8];
         end
      end
      @(posedge clk); #1;
      chk("a_read_valid", 16'(a_rv), 16'(rd));
      chk("b_read_valid", 16'(b_rv), 16'(rd));
      pop_check();
   endtask

   task automatic idle();
      @(negedge clk);
      write = 1'b0; read = 1'b0;
      @(posedge clk); #1;
      chk("a_idle_valid", 16'(a_rv), 16'h0);
      chk("b_idle_valid", 16'(b_rv), 16'h0);
      chk("a_hold", 16'(a_dout), 16'(last_a));
      chk("b_hold", b_dout, last_b);
   endtask

   task automatic sweep(input int restart_at, input int lock_cyc);
      int  na;
      int  nb;
      bit  done;
      @(negedge clk);
      reset = 1'b1;
      write = 1'b1; write_addr = 4'd1;
      a_din = 8'hEE; a_be = 1'b1;
      b_din = 16'hEEEE; b_be = 2'b11;
      read = 1'b1; read_addr = 4'd1;
      @(posedge clk); #1;
      chk("rst_a_busy", 16'(a_busy), 16'h1);
      chk("rst_b_busy", 16'(b_busy), 16'h1);
      chk("rst_a_valid", 16'(a_rv), 16'h0);
      chk("rst_b_valid", 16'(b_rv), 16'h0);
      chk("rst_a_dout", 16'(a_dout), 16'h0);
      chk("rst_b_dout", b_dout, 16'h0);
      @(negedge clk);
      reset = 1'b0; write = 1'b0; read = 1'b0;
      if (restart_at > 0) begin
         repeat (restart_at) @(posedge clk);
         @(negedge clk);
         reset = 1'b1;
         @(posedge clk); #1;
         chk("mid_a_busy", 16'(a_busy), 16'h1);
         chk("mid_b_busy", 16'(b_busy), 16'h1);
         @(negedge clk);
         reset = 1'b0;
      end
      for (int i = 0; i < 16; i++) ma[i] = 8'h0;
      for (int i = 0; i < 12; i++) mb[i] = 16'h0;
      last_a = 8'h0;
      last_b = 16'h0;
      na = 1;
      nb = 1;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         if (c == lock_cyc) begin
            write = 1'b1; write_addr = 4'd2;
            a_din = 8'h77; a_be = 1'b1;
            b_din = 16'h7777; b_be = 2'b11;
            read = 1'b1; read_addr = 4'd2;
         end
         @(posedge clk); #1;
         if (a_busy) na++;
         if (b_busy) nb++;
         if (c == lock_cyc) begin
            chk("lock_a_valid", 16'(a_rv), 16'h0);
            chk("lock_b_valid", 16'(b_rv), 16'h0);
         end
         @(negedge clk);
         write = 1'b0; read = 1'b0;
         done = !a_busy && !b_busy;
      end
      chk("sweep_done", 16'(done), 16'h1);
      chk("a_busy_cycles", 16'(na), 16'd16);
      chk("b_busy_cycles", 16'(nb), 16'd12);
   endtask

   initial begin
      reset = 1'b1;
      write = 1'b0; write_addr = 4'd0;
      read = 1'b0; read_addr = 4'd0;
      a_din = 8'h0; a_be = 1'b0;
      b_din = 16'h0; b_be = 2'b00;
      last_a = 8'h0;
      last_b = 16'h0;
      for (int i = 0; i < 16; i++) ma[i] = 8'h0;
      for (int i = 0; i < 12; i++) mb[i] = 16'h0;

      repeat (3) begin
         @(posedge clk); #1;
         chk("held_a_busy", 16'(a_busy), 16'h1);
         chk("held_b_busy", 16'(b_busy), 16'h1);
      end

      sweep(0, 2);

      for (int i = 0; i < 16; i++)
         op(0, 4'd0, 8'h0, 1'b0, 16'h0, 2'b00, 1, 4'(i));

      op(1, 4'd3, 8'hA5, 1'b1, 16'hBEEF, 2'b11, 0, 4'd0);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd3);
      chk("a_write_read_a5", 16'(last_a), 16'h00A5);

      op(1, 4'd7, 8'h34, 1'b1, 16'h1234, 2'b11, 0, 4'd0);
      op(1, 4'd7, 8'hFF, 1'b1, 16'hFFFF, 2'b01, 0, 4'd0);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd7);
      chk("b_byte_en_12ff", last_b, 16'h12FF);

      op(1, 4'd3, 8'h5A, 1'b0, 16'h5A5A, 2'b00, 0, 4'd0);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd3);

      op(1, 4'd5, 8'h11, 1'b1, 16'h1111, 2'b11, 0, 4'd0);
      op(1, 4'd5, 8'h22, 1'b1, 16'hAB22, 2'b01, 1, 4'd5);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd5);
      chk("a_collision_later", 16'(last_a), 16'h0022);

      op(1, 4'd6, 8'h66, 1'b1, 16'h6666, 2'b10, 1, 4'd3);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd6);
      idle();
      idle();

      op(1, 4'd13, 8'h55, 1'b1, 16'h5555, 2'b11, 0, 4'd0);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd13);
      op(1, 4'd11, 8'hC3, 1'b1, 16'hC3C3, 2'b11, 1, 4'd2);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd11);

      sweep(5, -1);
      op(1, 4'd13, 8'h55, 1'b1, 16'h5555, 2'b11, 0, 4'd0);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd13);
      chk("b_oor_read_zero", b_dout, 16'h0000);
      op(0, 4'd0, 8'h00, 1'b0, 16'h0000, 2'b00, 1, 4'd7);

      chk("a_queue_empty", 16'(qa.size()), 16'h0);
      chk("b_queue_empty", 16'(qb.size()), 16'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/syn_dp_ram_param.md
SYN_DP_RAM_PARAM -- requirements
Module: syn_dp_ram_param

Interface
REQ-001 Parameter RAM_WIDTH, default 8, data word width in bits; SHALL be a nonzero multiple of 8.
REQ-002 Parameter RAM_DEPTH, default 16, number of words; SHALL be in the range 2 to 2**ADDR_SIZE.
REQ-003 Parameter ADDR_SIZE, default 4, address width in bits.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 write  input  1  write request.
REQ-007 write_addr  input  ADDR_SIZE  write word address.
REQ-008 data_in  input  RAM_WIDTH  write data.
REQ-009 byte_en  input  RAM_WIDTH/8  per-byte write enable; bit k SHALL gate data_in[8k+7:8k].
REQ-010 read  input  1  read request.
REQ-011 read_addr  input  ADDR_SIZE  read word address.
REQ-012 data_out  output  RAM_WIDTH  registered read data.
REQ-013 read_valid  output  1  one-cycle pulse; data_out is updated this cycle.
REQ-014 busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-015 The block SHALL use a two-state FSM: CLEAR (sweep) and READY.
REQ-016 In CLEAR, each rising edge with reset low SHALL zero mem[clr_cnt], increment clr_cnt, and enter READY after writing RAM_DEPTH-1.
REQ-017 busy SHALL be high in CLEAR and low in READY, and SHALL stay high for exactly RAM_DEPTH cycles after reset deasserts.
REQ-018 In CLEAR, write and read SHALL be ignored, and read_valid SHALL stay 0.
REQ-019 In READY, write=1 with write_addr<RAM_DEPTH SHALL update only the bytes of mem[write_addr] whose byte_en bit is 1.
REQ-020 write=1 with byte_en all zero SHALL leave memory unchanged.
REQ-021 In READY, read=1 SHALL load data_out on that edge, giving 1-cycle latency, and SHALL set read_valid=1 for that one cycle.
REQ-022 read=0 SHALL hold data_out and clear read_valid.
REQ-023 When write_addr>=RAM_DEPTH, the write SHALL be discarded.
REQ-024 When read_addr>=RAM_DEPTH, the read SHALL return 0 with read_valid=1.
REQ-025 Simultaneous reads and writes to different addresses SHALL both complete in the same cycle.
REQ-026 For a simultaneous read and write to the same address, data_out SHALL follow the REQ-036 and REQ-037 rule.
REQ-027 Back-to-back reads on consecutive cycles SHALL produce read_valid high continuously, one new word per cycle.

Reset
REQ-028 An edge with reset=1 SHALL set data_out=0, read_valid=0, busy=1, clr_cnt=0 and the state to CLEAR.
REQ-029 reset=1 SHALL override write and read on that edge.
REQ-030 Memory contents SHALL NOT be altered on the reset edge itself; the sweep clears them afterwards.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-032 Reset asserted in READY SHALL discard any pending write and read in that cycle.
REQ-033 While reset is held high, busy SHALL remain 1 and clr_cnt SHALL remain 0.

Configuration
REQ-034 Macro SYN_DP_RAM_BYPASS_EN SHALL select read-during-write behaviour.
REQ-035 The macro SHALL NOT affect any other behaviour.
REQ-036 With SYN_DP_RAM_BYPASS_EN defined, a same-address read and write SHALL return on data_out the new bytes where byte_en=1 and the stored bytes elsewhere.
REQ-037 Without SYN_DP_RAM_BYPASS_EN, a same-address read and write SHALL return the pre-write contents; the write still takes effect.

Verification
REQ-038 Reset sweep: pulse reset 1 cycle, defaults -> busy high for exactly 16 cycles; then read every address 0..15 -> data_out=0x00 each time, read_valid high each cycle.
REQ-039 Write then read: write 0xA5 to address 3, then read address 3 next cycle -> data_out=0xA5 with read_valid one cycle after read.
REQ-040 Byte enables: RAM_WIDTH=16; write 0x1234 to address 7 with byte_en=11; write 0xFFFF to address 7 with byte_en=01; read address 7 -> 0x12FF.
REQ-041 Collision: address 5 holds 0x11; in one cycle write 0x22 and read address 5 -> data_out=0x22 with the macro, 0x11 without; a later read returns 0x22 in both builds.
REQ-042 Busy lockout: write 0x77 to address 2 on cycle 3 of the sweep; after busy falls, read address 2 -> 0x00.
REQ-043 Mid-sweep reset and out of range: RAM_DEPTH=12; reassert reset on sweep cycle 5 -> busy high for exactly 12 cycles after reset release; write 0x55 to address 13 is discarded; read address 13 -> 0x00 with read_valid=1.
